mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 185 ++++++++++++++++++
 tb/tb_mem_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// RV32I memory stage: issues data-memory requests, builds store masks, stalls
// on outstanding accesses and registers MEM/WB. Option: MISALIGN_CHECK_EN.
package mem_stage_pkg;
    typedef enum logic [3:0] {
        alu_out  = 4'd0,
        br_en    = 4'd1,
        u_imm    = 4'd2,
        lw       = 4'd3,
        pc_plus4 = 4'd4,
        lb       = 4'd5,
        lbu      = 4'd6,
        lh       = 4'd7,
        lhu      = 4'd8
    } regfilemux_sel_t;
endpackage

module mem_stage
    import mem_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_mem_valid,
    input  logic [4:0]      ex_mem_rd,
    input  regfilemux_sel_t ex_mem_regfile_sel,
    input  logic            ex_mem_mem_read,
    input  logic            ex_mem_mem_write,
    input  logic [2:0]      ex_mem_store_funct3,
    input  logic [31:0]     ex_mem_alu_out,
    input  logic [31:0]     ex_mem_rs2_out,
    output logic            dmem_read,
    output logic            dmem_write,
    output logic [31:0]     dmem_address,
    output logic [31:0]     dmem_wdata,
    output logic [3:0]      dmem_mbe,
    input  logic [31:0]     dmem_rdata,
    input  logic            dmem_resp,
    output logic            stall_mem,
    output logic            mem_wb_valid,
    output logic [4:0]      mem_wb_rd,
    output regfilemux_sel_t mem_wb_regfile_sel,
    output logic [31:0]     mem_wb_alu_out,
    output logic [31:0]     mem_wb_mem_out,
`ifdef MISALIGN_CHECK_EN
    output logic            misaligned_flag,
`endif
    output logic            flush_mem_wb
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    state_t state, state_next;

    localparam logic [2:0] FUNCT3_SB = 3'b000;
    localparam logic [2:0] FUNCT3_SH = 3'b001;

    function automatic logic [3:0] store_mbe(input logic [2:0] funct3,
                                             input logic [1:0] addr);
        case (funct3)
            FUNCT3_SB: return 4'b0001 << addr;
            FUNCT3_SH: return 4'b0011 << {addr[1], 1'b0};
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                                input logic [31:0] rs2);
        case (funct3)
            FUNCT3_SB: return {4{rs2[7:0]}};
            FUNCT3_SH: return {2{rs2[15:0]}};
            default:   return rs2;
        endcase
    endfunction

`ifdef MISALIGN_CHECK_EN
    // Word ops need addr[1:0]==0, halfword ops need addr[0]==0; bytes never trap.
    function automatic logic is_misaligned(input logic            rd_op,
                                           input logic            wr_op,
                                           input regfilemux_sel_t sel,
                                           input logic [2:0]      funct3,
                                           input logic [1:0]      addr);
        logic bad;
        bad = 1'b0;
        if (rd_op) begin
            case (sel)
                lw:      bad = (addr != 2'b00);
                lh, lhu: bad = addr[0];
                default: bad = 1'b0;
            endcase
        end else if (wr_op) begin
            case (funct3)
                FUNCT3_SH: bad = addr[0];
                FUNCT3_SB: bad = 1'b0;
                default:   bad = (addr != 2'b00);
            endcase
        end
        return bad;
    endfunction
`endif

    logic raw_op;
    logic misaligned;
    logic mem_op;

    assign raw_op = ex_mem_valid & (ex_mem_mem_read | ex_mem_mem_write);

`ifdef MISALIGN_CHECK_EN
    assign misaligned = raw_op & is_misaligned(ex_mem_mem_read, ex_mem_mem_write,
                                               ex_mem_regfile_sel, ex_mem_store_funct3,
                                               ex_mem_alu_out[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    assign mem_op = raw_op & ~misaligned;

    // ---- Stage boundary: EX/MEM fields -> data-memory request ----
    assign dmem_read    = ex_mem_mem_read  & mem_op;
    assign dmem_write   = ex_mem_mem_write & mem_op;
    assign dmem_address = {ex_mem_alu_out[31:2], 2'b00};
    assign dmem_wdata   = store_wdata(ex_mem_store_funct3, ex_mem_rs2_out);
    assign dmem_mbe     = ex_mem_mem_write ? store_mbe(ex_mem_store_funct3, ex_mem_alu_out[1:0])
                                           : 4'b1111;
    assign stall_mem    = mem_op & ~dmem_resp;

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (mem_op && !dmem_resp) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // A response without a live op is stray and must not end the access.
                if (mem_op && dmem_resp) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---- Stage boundary: MEM/WB register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_wb_valid       <= 1'b0;
            mem_wb_rd          <= 5'd0;
            mem_wb_regfile_sel <= alu_out;
            mem_wb_alu_out     <= 32'd0;
            mem_wb_mem_out     <= 32'd0;
        end else if (stall_mem) begin
            mem_wb_valid <= 1'b0;
        end else begin
            mem_wb_valid       <= ex_mem_valid & ~misaligned;
            mem_wb_rd          <= ex_mem_rd;
            mem_wb_regfile_sel <= ex_mem_regfile_sel;
            mem_wb_alu_out     <= ex_mem_alu_out;
            mem_wb_mem_out     <= (dmem_read && dmem_resp) ? dmem_rdata : 32'd0;
        end
    end

`ifdef MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misaligned_flag <= 1'b0;
        end else if (misaligned) begin
            misaligned_flag <= 1'b1;
        end
    end
`endif

    assign flush_mem_wb = ~mem_wb_valid;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load/store masking, stall timing,
// reset during an access and the misaligned-halfword case.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic            clk;
    logic            rst;
    logic            ex_mem_valid;
    logic [4:0]      ex_mem_rd;
    regfilemux_sel_t ex_mem_regfile_sel;
    logic            ex_mem_mem_read;
    logic            ex_mem_mem_write;
    logic [2:0]      ex_mem_store_funct3;
    logic [31:0]     ex_mem_alu_out;
    logic [31:0]     ex_mem_rs2_out;
    logic            dmem_read;
    logic            dmem_write;
    logic [31:0]     dmem_address;
    logic [31:0]     dmem_wdata;
    logic [3:0]      dmem_mbe;
    logic [31:0]     dmem_rdata;
    logic            dmem_resp;
    logic            stall_mem;
    logic            mem_wb_valid;
    logic [4:0]      mem_wb_rd;
    regfilemux_sel_t mem_wb_regfile_sel;
    logic [31:0]     mem_wb_alu_out;
    logic [31:0]     mem_wb_mem_out;
`ifdef MISALIGN_CHECK_EN
    logic            misaligned_flag;
`endif
    logic            flush_mem_wb;

    int n_cmp = 0;
    int n_bad = 0;

    mem_stage dut (
        .clk                 (clk),
        .rst                 (rst),
        .ex_mem_valid        (ex_mem_valid),
        .ex_mem_rd           (ex_mem_rd),
        .ex_mem_regfile_sel  (ex_mem_regfile_sel),
        .ex_mem_mem_read     (ex_mem_mem_read),
        .ex_mem_mem_write    (ex_mem_mem_write),
        .ex_mem_store_funct3 (ex_mem_store_funct3),
        .ex_mem_alu_out      (ex_mem_alu_out),
        .ex_mem_rs2_out      (ex_mem_rs2_out),
        .dmem_read           (dmem_read),
        .dmem_write          (dmem_write),
        .dmem_address        (dmem_address),
        .dmem_wdata          (dmem_wdata),
        .dmem_mbe            (dmem_mbe),
        .dmem_rdata          (dmem_rdata),
        .dmem_resp           (dmem_resp),
        .stall_mem           (stall_mem),
        .mem_wb_valid        (mem_wb_valid),
        .mem_wb_rd           (mem_wb_rd),
        .mem_wb_regfile_sel  (mem_wb_regfile_sel),
        .mem_wb_alu_out      (mem_wb_alu_out),
        .mem_wb_mem_out      (mem_wb_mem_out),
`ifdef MISALIGN_CHECK_EN
        .misaligned_flag     (misaligned_flag),
`endif
        .flush_mem_wb        (flush_mem_wb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic bubble();
        ex_mem_valid        = 1'b0;
        ex_mem_rd           = 5'd0;
        ex_mem_regfile_sel  = alu_out;
        ex_mem_mem_read     = 1'b0;
        ex_mem_mem_write    = 1'b0;
        ex_mem_store_funct3 = 3'b010;
        ex_mem_alu_out      = 32'd0;
        ex_mem_rs2_out      = 32'd0;
        dmem_rdata          = 32'd0;
        dmem_resp           = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd, input regfilemux_sel_t sel, input logic [31:0] addr);
        bubble();
        ex_mem_valid       = 1'b1;
        ex_mem_rd          = rd;
        ex_mem_regfile_sel = sel;
        ex_mem_mem_read    = 1'b1;
        ex_mem_alu_out     = addr;
    endtask

    task automatic store(input logic [2:0] funct3, input logic [31:0] addr, input logic [31:0] data);
        bubble();
        ex_mem_valid        = 1'b1;
        ex_mem_mem_write    = 1'b1;
        ex_mem_store_funct3 = funct3;
        ex_mem_alu_out      = addr;
        ex_mem_rs2_out      = data;
    endtask

    initial begin
        rst = 1'b1;
        bubble();

        // Reset state
        tick();
        tick();
        check("rst_valid",   mem_wb_valid, 0);
        check("rst_rd",      mem_wb_rd, 0);
        check("rst_alu",     mem_wb_alu_out, 0);
        check("rst_memout",  mem_wb_mem_out, 0);
        check("rst_sel",     mem_wb_regfile_sel, 32'(alu_out));
        check("rst_flush",   flush_mem_wb, 1);
        check("rst_state",   32'(dut.state), 0);
        rst = 1'b0;

        // lw x5 @0x100, three stall cycles then response
        load(5'd5, lw, 32'h0000_0100);
        settle();
        check("lw_addr", dmem_address, 32'h0000_0100);
        check("lw_mbe",  dmem_mbe, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            check("lw_stall", stall_mem, 1);
            check("lw_read",  dmem_read, 1);
            check("lw_write", dmem_write, 0);
            tick();
            check("lw_bubble", mem_wb_valid, 0);
        end
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        settle();
        check("lw_resp_stall", stall_mem, 0);
        check("lw_resp_read",  dmem_read, 1);
        tick();
        bubble();
        check("lw_wb_valid", mem_wb_valid, 1);
        check("lw_wb_rd",    mem_wb_rd, 5);
        check("lw_wb_data",  mem_wb_mem_out, 32'hDEAD_BEEF);
        check("lw_wb_alu",   mem_wb_alu_out, 32'h0000_0100);
        check("lw_flush",    flush_mem_wb, 0);
        check("lw_state",    32'(dut.state), 0);

        // sb @0x203, zero-wait
        store(3'b000, 32'h0000_0203, 32'h0000_00A5);
        dmem_resp = 1'b1;
        settle();
        check("sb_mbe",   dmem_mbe, 4'b1000);
        check("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        check("sb_addr",  dmem_address, 32'h0000_0200);
        check("sb_stall", stall_mem, 0);
        check("sb_write", dmem_write, 1);
        check("sb_read",  dmem_read, 0);
        tick();
        check("sb_wb_valid",  mem_wb_valid, 1);
        check("sb_wb_memout", mem_wb_mem_out, 0);

        // sh @0x102 and sw @0x104, zero-wait
        store(3'b001, 32'h0000_0102, 32'h1234_BEEF);
        dmem_resp = 1'b1;
        settle();
        check("sh_mbe",   dmem_mbe, 4'b1100);
        check("sh_wdata", dmem_wdata, 32'hBEEF_BEEF);
        tick();
        store(3'b010, 32'h0000_0104, 32'h1234_5678);
        dmem_resp = 1'b1;
        settle();
        check("sw_mbe",   dmem_mbe, 4'b1111);
        check("sw_wdata", dmem_wdata, 32'h1234_5678);
        check("sw_addr",  dmem_address, 32'h0000_0104);
        tick();

        // ALU op then lw with 2-cycle latency
        bubble();
        ex_mem_valid   = 1'b1;
        ex_mem_rd      = 5'd7;
        ex_mem_alu_out = 32'h0000_0055;
        settle();
        check("alu_stall", stall_mem, 0);
        check("alu_read",  dmem_read, 0);
        tick();
        load(5'd8, lw, 32'h0000_0300);
        settle();
        check("alu_wb_valid", mem_wb_valid, 1);
        check("alu_wb_rd",    mem_wb_rd, 7);
        check("alu_wb_alu",   mem_wb_alu_out, 32'h0000_0055);
        check("alu_wb_mem",   mem_wb_mem_out, 0);
        tick();
        check("b2_flush1", flush_mem_wb, 1);
        tick();
        check("b2_flush2", flush_mem_wb, 1);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h1122_3344;
        settle();
        check("b2_resp_stall", stall_mem, 0);
        tick();
        bubble();
        check("b2_wb_valid", mem_wb_valid, 1);
        check("b2_wb_rd",    mem_wb_rd, 8);
        check("b2_wb_data",  mem_wb_mem_out, 32'h1122_3344);

        // Back-to-back zero-wait loads
        load(5'd9, lw, 32'h0000_0400);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hAAAA_0001;
        settle();
        check("bb1_read", dmem_read, 1);
        tick();
        load(5'd10, lw, 32'h0000_0404);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hBBBB_0002;
        settle();
        check("bb2_read",  dmem_read, 1);
        check("bb1_wb",    mem_wb_mem_out, 32'hAAAA_0001);
        tick();
        bubble();
        check("bb2_wb",    mem_wb_mem_out, 32'hBBBB_0002);
        check("bb2_wb_rd", mem_wb_rd, 10);

        // Reset during the 2nd ACCESS cycle of a pending load
        load(5'd11, lw, 32'h0000_0500);
        tick();
        check("ra_state_acc", 32'(dut.state), 1);
        tick();
        rst = 1'b1;
        bubble();
        tick();
        rst = 1'b0;
        check("ra_state", 32'(dut.state), 0);
        check("ra_valid", mem_wb_valid, 0);
        check("ra_flush", flush_mem_wb, 1);
        dmem_resp  = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        settle();
        check("ra_late_stall", stall_mem, 0);
        check("ra_late_read",  dmem_read, 0);
        tick();
        dmem_resp = 1'b0;
        check("ra_late_valid",  mem_wb_valid, 0);
        check("ra_late_memout", mem_wb_mem_out, 0);
        check("ra_late_state",  32'(dut.state), 0);

        // lh @0x101
        load(5'd12, lh, 32'h0000_0101);
        settle();
`ifdef MISALIGN_CHECK_EN
        check("mis_read",  dmem_read, 0);
        check("mis_stall", stall_mem, 0);
        tick();
        bubble();
        check("mis_flag",  misaligned_flag, 1);
        check("mis_valid", mem_wb_valid, 0);
        tick();
        check("mis_flag_hold", misaligned_flag, 1);
`else
        check("lh_read",  dmem_read, 1);
        check("lh_addr",  dmem_address, 32'h0000_0100);
        check("lh_mbe",   dmem_mbe, 4'b1111);
        check("lh_stall", stall_mem, 1);
        tick();
        dmem_resp  = 1'b1;
        dmem_rdata = 32'h0BAD_CAFE;
        tick();
        bubble();
        check("lh_wb_valid", mem_wb_valid, 1);
        check("lh_wb_data",  mem_wb_mem_out, 32'h0BAD_CAFE);
        check("lh_wb_alu",   mem_wb_alu_out, 32'h0000_0101);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
